// File: rtl/axil_uart_cmd_master.sv
// axil_uart_cmd_master
// AXI4-Lite master that turns single byte commands into complete UART
// peripheral transactions: it polls the status register until the target
// FIFO is usable (or gives up after MAX_POLLS reads), then writes the TX
// register or reads the RX register and reports the outcome with a
// one-cycle response pulse.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   cmd_valid/cmd_ready             command handshake (ready only when idle)
//   cmd_rd, cmd_wdata               0 = write cmd_wdata to TX, 1 = read RX
//   rsp_valid                       one-cycle completion pulse
//   rsp_data, rsp_err, rsp_timeout  result, held until the next response
//   m_axi_aw*/w*/b*/ar*/r*          AXI4-Lite master channels
module axil_uart_cmd_master #(
    parameter int              ADDR_W       = 6,
    parameter int              DATA_W       = 32,
    parameter logic [ADDR_W-1:0] TX_ADDR    = 'h00,
    parameter logic [ADDR_W-1:0] RX_ADDR    = 'h04,
    parameter logic [ADDR_W-1:0] STAT_ADDR  = 'h08,
    parameter int              TX_FULL_BIT  = 0,
    parameter int              RX_EMPTY_BIT = 1,
    parameter int              MAX_POLLS    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_rd,
    input  logic [7:0]          cmd_wdata,
    output logic                rsp_valid,
    output logic [7:0]          rsp_data,
    output logic                rsp_err,
    output logic                rsp_timeout,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    output logic [ADDR_W-1:0]   m_axi_araddr,
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,
    input  logic [DATA_W-1:0]   m_axi_rdata,
    input  logic [1:0]          m_axi_rresp,
    input  logic                m_axi_rvalid,
    output logic                m_axi_rready
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(MAX_POLLS + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_POLLS);

    typedef enum logic [3:0] {
        IDLE, POLL_AR, POLL_R, CHECK, WR, WR_B, RD_AR, RD_R, RESP
    } state_t;

    state_t           state;
    state_t           next_state;
    logic             cmd_is_rd;
    logic [7:0]       cmd_byte;
    logic [CNT_W-1:0] poll_cnt;
    logic             blocked;
    logic             err_q;
    logic             timeout_q;
    logic [7:0]       data_q;
    logic             aw_done;
    logic             w_done;
    logic             aw_fin;
    logic             w_fin;

    // Only bit 1 of a response distinguishes error from success, and only
    // the low byte / two status bits of read data matter.
    logic unused_bits;
    assign unused_bits = ^{m_axi_rresp[0], m_axi_bresp[0], m_axi_rdata};

    // A channel counts as finished if it completed earlier or completes now.
    assign aw_fin = aw_done | (m_axi_awvalid & m_axi_awready);
    assign w_fin  = w_done  | (m_axi_wvalid  & m_axi_wready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (cmd_valid && cmd_ready) next_state = POLL_AR;
            POLL_AR: if (m_axi_arvalid && m_axi_arready) next_state = POLL_R;
            POLL_R:  if (m_axi_rvalid) next_state = m_axi_rresp[1] ? RESP : CHECK;
            CHECK: begin
                if (!blocked)                next_state = cmd_is_rd ? RD_AR : WR;
                else if (poll_cnt == MAX_CNT) next_state = RESP;
                else                          next_state = POLL_AR;
            end
            WR:      if (aw_fin && w_fin) next_state = WR_B;
            WR_B:    if (m_axi_bvalid) next_state = RESP;
            RD_AR:   if (m_axi_arvalid && m_axi_arready) next_state = RD_R;
            RD_R:    if (m_axi_rvalid) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Command latch, poll bookkeeping and the result being built up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_is_rd <= 1'b0;
            cmd_byte  <= '0;
            poll_cnt  <= '0;
            blocked   <= 1'b0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
            data_q    <= '0;
        end else begin
            case (state)
                IDLE: if (cmd_valid && cmd_ready) begin
                    cmd_is_rd <= cmd_rd;
                    cmd_byte  <= cmd_wdata;
                    poll_cnt  <= '0;
                    err_q     <= 1'b0;
                    timeout_q <= 1'b0;
                    data_q    <= '0;
                end
                POLL_R: if (m_axi_rvalid) begin
                    if (m_axi_rresp[1]) begin
                        err_q <= 1'b1;
                    end else begin
                        blocked  <= cmd_is_rd ? m_axi_rdata[RX_EMPTY_BIT]
                                              : m_axi_rdata[TX_FULL_BIT];
                        poll_cnt <= poll_cnt + CNT_W'(1);
                    end
                end
                CHECK: if (blocked && poll_cnt == MAX_CNT) begin
                    err_q     <= 1'b1;
                    timeout_q <= 1'b1;
                end
                WR_B: if (m_axi_bvalid) err_q <= m_axi_bresp[1];
                RD_R: if (m_axi_rvalid) begin
                    err_q  <= m_axi_rresp[1];
                    data_q <= m_axi_rresp[1] ? 8'h00 : m_axi_rdata[7:0];
                end
                default: ;
            endcase
        end
    end

    // AXI channel outputs are decoded from the next state so every valid
    // and ready is a flop yet still drops right after its handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axi_arvalid <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_rready  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_awvalid <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
        end else begin
            m_axi_arvalid <= (next_state == POLL_AR) || (next_state == RD_AR);
            if (next_state == POLL_AR)    m_axi_araddr <= STAT_ADDR;
            else if (next_state == RD_AR) m_axi_araddr <= RX_ADDR;
            m_axi_rready <= (next_state == POLL_R) || (next_state == RD_R);
            m_axi_bready <= (next_state == WR_B);

            if (state != WR && next_state == WR) begin
                m_axi_awvalid <= 1'b1;
                m_axi_wvalid  <= 1'b1;
                m_axi_awaddr  <= TX_ADDR;
                m_axi_wdata   <= DATA_W'(cmd_byte);
                m_axi_wstrb   <= STRB_W'(1);
                aw_done       <= 1'b0;
                w_done        <= 1'b0;
            end else begin
                if (m_axi_awvalid && m_axi_awready) begin
                    m_axi_awvalid <= 1'b0;
                    aw_done       <= 1'b1;
                end
                if (m_axi_wvalid && m_axi_wready) begin
                    m_axi_wvalid <= 1'b0;
                    w_done       <= 1'b1;
                end
            end
        end
    end

    // Command-side outputs; the response fields are copied out of RESP so
    // they stay put until the next completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            cmd_ready <= (next_state == IDLE);
            rsp_valid <= (state == RESP);
            if (state == RESP) begin
                rsp_data    <= data_q;
                rsp_err     <= err_q;
                rsp_timeout <= timeout_q;
            end
        end
    end

endmodule
